muldiv_seq: RTL

Multicycle signed multiply/divide sequencer that takes the MUL and DIV operations off the single-cycle ALU path. It runs a radix-2 shift-add multiply or a restoring divide over WIDTH iterations. A start/busy/done handshake lets the control unit stall the pipeline while the operation runs. It sits beside the ALU in the execute stage, driven by the same 4-bit ALU control code and operand buses.

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/muldiv_step.sv | 20 ++
 rtl/muldiv_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes shared with the ALU decoder, sequencer FSM states and default width
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on a 2W accumulator
module muldiv_step #(
    parameter int W = 32
) (
    input  logic           i_div,
    input  logic [2*W-1:0] i_acc,
    input  logic [W-1:0]   i_opnd,
    output logic [2*W-1:0] o_acc
);
    logic [W:0]     w_sum;
    logic [W:0]     w_trial;
    logic [2*W-1:0] w_shl;

    // MUL: {hi, multiplier}; DIV: {rem, quotient} with the dividend shifting out of the low half
    assign w_sum   = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    assign w_shl   = i_acc << 1;
    assign w_trial = {1'b0, w_shl[2*W-1:W]} - {1'b0, i_opnd};
    assign o_acc   = i_div ? (w_trial[W] ? w_shl : {w_trial[W-1:0], w_shl[W-1:1], 1'b1})
                           : {w_sum, i_acc[W-1:1]};
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multicycle signed MUL/DIV sequencer with start/busy/done handshake
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_alu_cnt,
    input  logic [WIDTH-1:0] i_input1,
    input  logic [WIDTH-1:0] i_input2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    state_t             r_state, w_next;
    logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_dbz;
    logic [WIDTH-1:0]   r_opnd, r_result, r_result_hi;
    logic [2*WIDTH-1:0] r_acc, w_step, w_prod;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   w_abs1, w_abs2, w_q, w_r, w_lo_s, w_res, w_res_hi;
    logic               w_start, w_div, w_dz_in;

    assign w_abs1  = i_input1[WIDTH-1] ? -i_input1 : i_input1;
    assign w_abs2  = i_input2[WIDTH-1] ? -i_input2 : i_input2;
    assign w_div   = i_alu_cnt == OP_DIV;
    assign w_dz_in = w_div && (i_input2 == '0);
    assign w_start = (r_state == IDLE) && i_start && !i_flush && (i_alu_cnt == OP_MUL || w_div);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_dz_in ? SIGN : CALC;
            CALC:    if (r_cnt == CW'(WIDTH-1)) w_next = SIGN;
            default: w_next = IDLE;
        endcase
        if (i_flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    muldiv_step #(.W(WIDTH)) u_step (
        .i_div  (r_is_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_step)
    );

    // On divide-by-zero the low half still holds |input1|, so re-signing it recovers input1
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_q      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_lo_s   = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_res    = !r_is_div ? w_prod[WIDTH-1:0] : r_dz ? '1 : w_q;
    assign w_res_hi = !r_is_div ? w_prod[2*WIDTH-1:WIDTH] : r_dz ? w_lo_s : w_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
        end else begin
            r_done <= (r_state == SIGN) && !i_flush;
            if (w_start) begin
                r_is_div <= w_div;
                r_opnd   <= w_div ? w_abs2 : w_abs1;
                r_acc    <= {{WIDTH{1'b0}}, w_div ? w_abs1 : w_abs2};
                r_neg_q  <= i_input1[WIDTH-1] ^ i_input2[WIDTH-1];
                r_neg_r  <= i_input1[WIDTH-1];
                r_dz     <= w_dz_in;
                r_cnt    <= '0;
            end else if (r_state == CALC) begin
                r_acc <= w_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == SIGN && !i_flush) begin
                r_result    <= w_res;
                r_result_hi <= w_res_hi;
                r_dbz       <= r_dz;
            end
        end
    end

    assign o_busy        = r_state != IDLE;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_result_hi   = r_result_hi;
    assign o_div_by_zero = r_dbz;
endmodule
